cnn_cell_update: RTL

CNN_CELL_UPDATE -- requirements
Module: cnn_cell_update

---
 rtl/cnn_cell_update_pkg.sv | 31 +++
 rtl/cnn_cell_update_if.sv | 21 ++
 rtl/cnn_sat_clamp.sv | 15 +
 rtl/cnn_cell_update.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cnn_cell_update_pkg.sv
// Shared types and fixed-point helpers for the CNN cell datapath.
// Also used by the cell-equation block for its own saturation.
package cnn_cell_update_pkg;

  localparam int WIDTH_D = 8;
  localparam int FRAC_D  = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  function automatic int sat(input int v, input int bits);
    int hi;
    int lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int clamp(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/cnn_cell_update_if.sv
// Template-sum handshake between the cell-equation block
// and the state-update block.
interface cnn_cell_update_if #(
  parameter int WIDTH = 8
);
  logic signed [2*WIDTH:0] sum_in;
  logic                    sum_valid;
  logic                    sum_ready;

  modport master (
    output sum_in,
    output sum_valid,
    input  sum_ready
  );

  modport slave (
    input  sum_in,
    input  sum_valid,
    output sum_ready
  );
endinterface

// File: rtl/cnn_sat_clamp.sv
// Piecewise-linear CNN output: y = clamp(x, -1.0, +1.0).
// Purely combinational.
module cnn_sat_clamp
  import cnn_cell_update_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int FRAC  = FRAC_D
) (
  input  logic signed [2*WIDTH:0] i_x,
  output logic signed [WIDTH:0]   o_y
);

  assign o_y = (WIDTH+1)'(clamp(int'(i_x), 1 << FRAC));

endmodule

// File: rtl/cnn_cell_update.sv
// CNN cell state integrator: forward-Euler step of
// dx/dt = -x + sum, output clamped to [-1, +1].
module cnn_cell_update
  import cnn_cell_update_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int FRAC     = FRAC_D,
  parameter int DT_SHIFT = 2,
  parameter int ITER_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [2*WIDTH:0] x0,
  input  logic [ITER_W-1:0]       max_iter,
  cnn_cell_update_if.slave        sum_if,
  output logic signed [WIDTH:0]   y,
  output logic                    y_valid,
  output logic [ITER_W-1:0]       iter,
  output logic                    busy,
  output logic                    done,
  output logic                    converged
);

  localparam int SW = 2*WIDTH + 1;
  localparam int DW = SW + 2;

  state_t r_state;
  state_t w_next;

  logic signed [SW-1:0] r_x;
  logic signed [SW-1:0] r_sum;
  logic [ITER_W-1:0]    r_max;

  logic signed [DW-1:0] w_sum_ext;
  logic signed [DW-1:0] w_x_ext;
  logic signed [DW-1:0] w_diff;
  logic signed [DW-1:0] w_delta;
  logic signed [DW-1:0] w_xsum;
  logic signed [SW-1:0] w_xnew;
  logic signed [SW-1:0] w_cin;
  logic signed [WIDTH:0] w_y;
  logic [ITER_W:0]      w_iter_inc;
  logic w_xfer;
  logic w_zero;
  logic w_last;
  logic w_go;
  logic w_upd;

  assign sum_if.sum_ready = (r_state == S_WAIT);
  assign busy = (r_state == S_WAIT) ||
                (r_state == S_UPDATE);

  assign w_xfer = sum_if.sum_valid && sum_if.sum_ready;
  assign w_upd  = (r_state == S_UPDATE);
  assign w_go   = start && ((r_state == S_IDLE) ||
                            (r_state == S_DONE));

  // Two guard bits keep the shifted difference exact.
  assign w_sum_ext = {{2{r_sum[SW-1]}}, r_sum};
  assign w_x_ext   = {{2{r_x[SW-1]}}, r_x};
  assign w_diff    = (w_sum_ext >>> FRAC) - w_x_ext;
  assign w_delta   = w_diff >>> DT_SHIFT;
  assign w_xsum    = w_x_ext + w_delta;
  assign w_xnew    = SW'(sat(int'(w_xsum), SW));

  assign w_iter_inc = {1'b0, iter} + 1'b1;
  assign w_zero = (w_delta == '0);
  assign w_last = (w_iter_inc == {1'b0, r_max});

  assign w_cin = w_upd ? w_xnew : x0;

  cnn_sat_clamp #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_clamp (
    .i_x (w_cin),
    .o_y (w_y)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_WAIT;
      S_WAIT:   if (w_xfer) w_next = S_UPDATE;
      S_UPDATE: w_next = (w_zero || w_last) ? S_DONE : S_WAIT;
      S_DONE:   if (start) w_next = S_WAIT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_sum     <= '0;
      r_max     <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      iter      <= '0;
      done      <= 1'b0;
      converged <= 1'b0;
    end else begin
      r_state <= w_next;
      y_valid <= 1'b0;
      if (w_go) begin
        r_x       <= x0;
        iter      <= '0;
        done      <= 1'b0;
        converged <= 1'b0;
        y         <= w_y;
        y_valid   <= 1'b1;
        r_max     <= (max_iter == '0) ? ITER_W'(1) : max_iter;
      end
      if (w_xfer) r_sum <= sum_if.sum_in;
      if (w_upd) begin
        r_x     <= w_xnew;
        iter    <= w_iter_inc[ITER_W-1:0];
        y       <= w_y;
        y_valid <= 1'b1;
        if (w_zero || w_last) begin
          done      <= 1'b1;
          converged <= w_zero;
        end
      end
    end
  end

endmodule
